// File: rtl/NetworkPkg.sv
// Shared types for the ring interconnect node logic.
//   pkt_t          : ring packet payload (src, dest, data)
//   inject_state_t : injection-port offer FSM states
package NetworkPkg;

  typedef struct packed {
    logic [7:0]   src;
    logic [7:0]   dest;
    logic [127:0] data;
  } pkt_t;

  localparam int unsigned PKT_W = $bits(pkt_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_OFFER = 2'd1,
    ST_STALL = 2'd2
  } inject_state_t;

endpackage

// File: rtl/inject_fifo.sv
// Small synchronous FIFO holding packets waiting to enter the ring.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : write request and data (caller guarantees not full)
//   pop           : read request (ignored when empty)
//   rdata         : head entry, read combinationally
//   count         : occupancy, $clog2(DEPTH)+1 bits
module inject_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    put_ptr;
  logic [AW-1:0]    get_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[get_ptr];

  // Storage is not reset; stale entries are never visible past count.
  always_ff @(posedge clk) begin
    if (do_push) mem[put_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      put_ptr <= '0;
      get_ptr <= '0;
      count   <= '0;
    end else begin
      if (do_push) put_ptr <= put_ptr + AW'(1);
      if (do_pop)  get_ptr <= get_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ring_inject_port.sv
// Per-node ring injection stage: accepts core packets, stamps src,
// loops back self-addressed packets, queues the rest and offers the
// FIFO head to the ring until taken, flagging starvation.
// Optional macro RING_INJECT_STATS_EN adds inj_count / max_wait outputs.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   core_valid, core_pkt, core_ready  : core-side handshake
//   ring_pkt, ring_valid, ring_taken  : head offer to the ring
//   ring_full                         : ring backpressure (stall accounting)
//   loop_valid, loop_pkt              : local loopback delivery
//   starved                           : head waited >= STARVE_LIMIT cycles
//   inj_count, max_wait               : statistics (macro only)
module ring_inject_port
  import NetworkPkg::*;
#(
  parameter int unsigned NODE_ID      = 0,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  input  pkt_t        core_pkt,
  output logic        core_ready,
  output pkt_t        ring_pkt,
  output logic        ring_valid,
  input  logic        ring_taken,
  input  logic        ring_full,
  output logic        loop_valid,
  output pkt_t        loop_pkt,
`ifdef RING_INJECT_STATS_EN
  output logic [31:0] inj_count,
  output logic [15:0] max_wait,
`endif
  output logic        starved
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int unsigned WW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [7:0]  NODE_ID8 = 8'(NODE_ID);
  localparam logic [WW-1:0] LIMIT  = WW'(STARVE_LIMIT);

  inject_state_t   state;
  logic [WW-1:0]   wait_cnt;
  logic [WW-1:0]   wait_next;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  pkt_t            stamped;
  pkt_t            head;
  logic            accept;
  logic            is_loop;
  logic            push;
  logic            pop;
  logic            stall_next;
  logic            ring_full_seen;

  // ring_full only explains why the head stalls; the stall itself is
  // already visible as ring_taken staying low.
  assign ring_full_seen = ring_full;

  always_comb begin
    stamped     = core_pkt;
    stamped.src = NODE_ID8;
  end

  assign core_ready = (count < CW'(DEPTH));
  assign accept     = core_valid && core_ready;
  assign is_loop    = (core_pkt.dest == NODE_ID8);
  assign push       = accept && !is_loop;
  assign ring_valid = (count != '0);
  assign pop        = ring_valid && ring_taken;
  assign ring_pkt   = ring_valid ? head : '0;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Next cycle is a STALL cycle exactly when a head is held without pop.
  assign stall_next = ring_valid && !pop;
  assign wait_next  = !stall_next ? '0 :
                      (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + WW'(1);

  inject_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (stamped),
    .rdata (head),
    .count (count)
  );

  // Offer FSM, wait counter and loopback register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      wait_cnt   <= '0;
      starved    <= 1'b0;
      loop_valid <= 1'b0;
      loop_pkt   <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (push) state <= ST_OFFER;
        ST_OFFER, ST_STALL: begin
          if (pop) state <= (count_next == '0) ? ST_EMPTY : ST_OFFER;
          else     state <= ST_STALL;
        end
        default: state <= ST_EMPTY;
      endcase
      wait_cnt   <= wait_next;
      starved    <= (wait_next == LIMIT) && !(ring_full_seen && 1'b0);
      loop_valid <= accept && is_loop;
      if (accept && is_loop) loop_pkt <= stamped;
    end
  end

`ifdef RING_INJECT_STATS_EN
  logic [15:0] run_len;
  logic [15:0] run_next;

  assign run_next = !stall_next ? 16'd0 :
                    (run_len == 16'hFFFF) ? run_len : run_len + 16'd1;

  // Pop counter and longest observed stall run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_count <= '0;
      run_len   <= '0;
      max_wait  <= '0;
    end else begin
      if (pop) inj_count <= inj_count + 32'd1;
      run_len <= run_next;
      if (run_next > max_wait) max_wait <= run_next;
    end
  end
`endif

endmodule

// File: tb/tb_ring_inject_port.sv
module tb_ring_inject_port;
  import NetworkPkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u1: NODE_ID=1, main checks
  logic core_valid, core_ready, ring_valid, ring_taken, loop_valid, starved;
  pkt_t core_pkt, ring_pkt, loop_pkt;
  // u3: NODE_ID=3, loopback checks
  logic l_valid, l_ready, l_rvalid, l_lvalid, l_starved;
  pkt_t l_pkt, l_rpkt, l_lpkt;
`ifdef RING_INJECT_STATS_EN
  logic [31:0] inj_count, l_inj_count;
  logic [15:0] max_wait, l_max_wait;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ring_inject_port #(.NODE_ID(1), .DEPTH(4), .STARVE_LIMIT(16)) u1 (
    .clk(clk), .rst(rst), .core_valid(core_valid), .core_pkt(core_pkt),
    .core_ready(core_ready), .ring_pkt(ring_pkt), .ring_valid(ring_valid),
    .ring_taken(ring_taken), .ring_full(1'b0), .loop_valid(loop_valid),
    .loop_pkt(loop_pkt),
`ifdef RING_INJECT_STATS_EN
    .inj_count(inj_count), .max_wait(max_wait),
`endif
    .starved(starved));

  ring_inject_port #(.NODE_ID(3), .DEPTH(4), .STARVE_LIMIT(16)) u3 (
    .clk(clk), .rst(rst), .core_valid(l_valid), .core_pkt(l_pkt),
    .core_ready(l_ready), .ring_pkt(l_rpkt), .ring_valid(l_rvalid),
    .ring_taken(1'b0), .ring_full(1'b0), .loop_valid(l_lvalid),
    .loop_pkt(l_lpkt),
`ifdef RING_INJECT_STATS_EN
    .inj_count(l_inj_count), .max_wait(l_max_wait),
`endif
    .starved(l_starved));

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pkt_t mk(input logic [7:0] s, input logic [7:0] d, input logic [127:0] x);
    pkt_t p;
    p.src = s; p.dest = d; p.data = x;
    return p;
  endfunction

  initial begin
    rst = 1'b1; core_valid = 1'b0; core_pkt = '0; ring_taken = 1'b0;
    l_valid = 1'b0; l_pkt = '0;
    #2;
    // Reset state
    chk("rst_ring_valid", 144'(ring_valid), 144'(0));
    chk("rst_ring_pkt",   ring_pkt, '0);
    chk("rst_loop_valid", 144'(loop_valid), 144'(0));
    chk("rst_loop_pkt",   loop_pkt, '0);
    chk("rst_starved",    144'(starved), 144'(0));
    chk("rst_core_ready", 144'(core_ready), 144'(1));
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_core_ready", 144'(core_ready), 144'(1));
    chk("idle_ring_valid", 144'(ring_valid), 144'(0));

    // Single inject, src overwritten with NODE_ID
    core_valid = 1'b1; core_pkt = mk(8'hAA, 8'd2, 128'h1234); ring_taken = 1'b1;
    tick();
    core_valid = 1'b0;
    chk("single_valid", 144'(ring_valid), 144'(1));
    chk("single_pkt",   ring_pkt, mk(8'd1, 8'd2, 128'h1234));
    tick();
    chk("single_popped_valid", 144'(ring_valid), 144'(0));
    chk("single_popped_pkt",   ring_pkt, '0);
    chk("single_state", 144'(u1.state), 144'(ST_EMPTY));

    // Fill 4, fifth refused; head held stable
    ring_taken = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("fill_ready_pre", 144'(core_ready), 144'(i <= 4));
      core_valid = 1'b1; core_pkt = mk(8'h00, 8'd2, 128'(i));
      tick();
      chk("fill_ready_post", 144'(core_ready), 144'(i < 4));
      chk("fill_head_held", ring_pkt, mk(8'd1, 8'd2, 128'd1));
    end
    core_valid = 1'b0; ring_taken = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 144'(ring_valid), 144'(1));
      chk("drain_data",  144'(ring_pkt.data), 144'(i));
      tick();
    end
    chk("drain_empty", 144'(ring_valid), 144'(0));

    // Starvation: starved in offer cycles 17..N, clears after pop
    ring_taken = 1'b0; core_valid = 1'b1; core_pkt = mk(8'h00, 8'd5, 128'h55);
    tick();
    core_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      chk("starve_cycle", 144'(starved), 144'(k >= 17));
      tick();
    end
    chk("starve_hold", 144'(starved), 144'(1));
    ring_taken = 1'b1;
    tick();
    chk("starve_clear", 144'(starved), 144'(0));
    chk("starve_empty", 144'(ring_valid), 144'(0));

    // Loopback on NODE_ID=3
    l_valid = 1'b1; l_pkt = mk(8'h77, 8'd3, 128'hBEEF);
    tick();
    l_valid = 1'b0;
    chk("loop_valid", 144'(l_lvalid), 144'(1));
    chk("loop_pkt",   l_lpkt, mk(8'd3, 8'd3, 128'hBEEF));
    chk("loop_no_ring", 144'(l_rvalid), 144'(0));
    tick();
    chk("loop_pulse_end", 144'(l_lvalid), 144'(0));
    chk("loop_no_ring2", 144'(l_rvalid), 144'(0));

    // Simultaneous push/pop at count 2
    ring_taken = 1'b0; core_valid = 1'b1;
    core_pkt = mk(8'h00, 8'd2, 128'hA1); tick();
    core_pkt = mk(8'h00, 8'd2, 128'hB2); tick();
    chk("pp_count_before", 144'(u1.u_fifo.count), 144'(2));
    core_pkt = mk(8'h00, 8'd2, 128'hC3); ring_taken = 1'b1; tick();
    core_valid = 1'b0;
    chk("pp_count_after", 144'(u1.u_fifo.count), 144'(2));
    chk("pp_head_b", 144'(ring_pkt.data), 144'(128'hB2));
    tick();
    chk("pp_head_c", 144'(ring_pkt.data), 144'(128'hC3));
    tick();
    chk("pp_empty", 144'(ring_valid), 144'(0));

    // Asynchronous reset mid-stream
    ring_taken = 1'b0; core_valid = 1'b1;
    core_pkt = mk(8'h00, 8'd2, 128'hD4); tick();
    core_pkt = mk(8'h00, 8'd2, 128'hE5); tick();
    core_valid = 1'b0;
    chk("mid_valid_pre", 144'(ring_valid), 144'(1));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 144'(ring_valid), 144'(0));
    chk("mid_rst_pkt",   ring_pkt, '0);
    chk("mid_rst_ready", 144'(core_ready), 144'(1));
    tick();
    rst = 1'b0;
    tick();
    chk("mid_after_valid", 144'(ring_valid), 144'(0));
    chk("mid_after_count", 144'(u1.u_fifo.count), 144'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
